// File: rtl/div_32_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared types and constants for the ALU arithmetic units.
//   div_state_t : divider FSM state encoding
//   DIV_ITER    : restoring steps per division
//   DIV_ZERO_Q  : quotient returned for a zero divisor
//   INT_MIN     : most negative 32-bit two's-complement value
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_32_if.sv
// -----------------------------------------------------------------------------
// div_32_if : start/done handshake and operand/result bus of the divider.
//   master : ALU control side (drives i_start, i_signed, a, b)
//   slave  : divider side (drives o_busy, o_done, results and flags)
// -----------------------------------------------------------------------------
interface div_32_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;
    logic             overflow;

    modport master (
        output i_start, i_signed, a, b,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_zero, overflow
    );

    modport slave (
        input  i_start, i_signed, a, b,
        output o_busy, o_done, o_quotient, o_remainder, o_div_zero, overflow
    );
endinterface

// File: rtl/div_32_step.sv
// -----------------------------------------------------------------------------
// div_step_33 : one combinational restoring-division step.
//   rem_i     : partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step_33 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Because rem_i < divisor_i, a non-negative diff is always < divisor_i
    // and fits in WIDTH bits; diff[WIDTH] is therefore a pure borrow flag.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_32.sv
// -----------------------------------------------------------------------------
// div_32 : multi-cycle restoring integer divider (quotient and remainder).
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : div_32_if.slave
//           i_start/i_signed/a/b in; o_busy, o_done (1-cycle pulse),
//           o_quotient, o_remainder, o_div_zero, overflow out (all registered)
// Build option: DIV_32_SIGNED_EN enables two's-complement operands
// (magnitude conversion, sign fix-up, overflow flag). Without it, i_signed
// is ignored and overflow stays 0; latency is identical in both builds.
//
// state | meaning
// IDLE  | waiting for i_start; results held
// CALC  | one restoring step per cycle, counter 0..31
// FIXUP | apply result signs, register results
// DONE  | o_done high for one cycle
// -----------------------------------------------------------------------------
module div_32
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    div_32_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sgn_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

`ifdef DIV_32_SIGNED_EN
    assign sgn_in = bus.i_signed;
`else
    logic unused_i_signed;
    assign unused_i_signed = bus.i_signed;
    assign sgn_in          = 1'b0;
`endif

    // Two's-complement negation of INT_MIN yields INT_MIN, which is exactly
    // the unsigned magnitude 2^31, so no special case is needed.
    assign a_mag = (sgn_in && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag = (sgn_in && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    div_step_33 #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = (bus.b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIXUP;
                end
            end
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dsr_d      = dsr_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        busy_d     = (state_d == CALC) || (state_d == FIXUP);
        done_d     = (state_d == DONE);

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    ovf_d = 1'b0;
                    if (bus.b == '0) begin
                        quot_d = WIDTH'(DIV_ZERO_Q);
                        remd_d = bus.a;
                        dz_d   = 1'b1;
                    end else begin
                        dvd_d      = a_mag;
                        dsr_d      = b_mag;
                        rem_d      = '0;
                        cnt_d      = '0;
                        qneg_d     = sgn_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_d     = sgn_in && bus.a[WIDTH-1];
                        ovf_pend_d = sgn_in && (bus.a == WIDTH'(INT_MIN))
                                            && (bus.b == '1);
                        quot_d     = '0;
                        remd_d     = '0;
                        dz_d       = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIXUP: begin
                quot_d = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
                remd_d = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
                ovf_d  = ovf_pend_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dsr_q      <= dsr_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_quotient  = quot_q;
    assign bus.o_remainder = remd_q;
    assign bus.o_div_zero  = dz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_div_32.sv
// -----------------------------------------------------------------------------
// tb_div_32 : self-checking bench for div_32. Expected results are computed
// by a behavioural model when a start is driven, queued, and compared when
// o_done pulses. Honours DIV_32_SIGNED_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_div_32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    div_32_if #(.WIDTH(32)) dif ();

    div_32 #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] aa, input logic [31:0] bb);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        bit   sgn_on;
`ifdef DIV_32_SIGNED_EN
        sgn_on = sgn;
`else
        sgn_on = 1'b0;
`endif
        sa  = aa;
        sbv = bb;
        e   = '0;
        if (bb == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = aa;
            e.dz = 1'b1;
        end else if (sgn_on) begin
            if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                e.q   = 32'h8000_0000;
                e.r   = 32'd0;
                e.ovf = 1'b1;
            end else begin
                e.q = sa / sbv;
                e.r = sa % sbv;
            end
        end else begin
            e.q = aa / bb;
            e.r = aa % bb;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (dif.o_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",  dif.o_quotient,  e.q);
                check("remainder", dif.o_remainder, e.r);
                check("div_zero",  32'(dif.o_div_zero), 32'(e.dz));
                check("overflow",  32'(dif.overflow),   32'(e.ovf));
            end
        end
    end

    task automatic do_div(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                          input bit poke_in_done);
        int lat;
        bit busy_ok;
        bit done_seen;
        @(negedge clk);
        dif.i_start  = 1'b1;
        dif.i_signed = sgn;
        dif.a        = aa;
        dif.b        = bb;
        sb.push_back(model(sgn, aa, bb));
        lat       = 0;
        busy_ok   = 1'b1;
        done_seen = 1'b0;
        while (!done_seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            dif.i_start = 1'b0;
            if (dif.o_done) done_seen = 1'b1;
            else if (!dif.o_busy) busy_ok = 1'b0;
        end
        check("latency", lat, (bb == 32'd0) ? 32'd1 : 32'd34);
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("busy_at_done", 32'(dif.o_busy), 32'd0);
        if (poke_in_done) begin
            dif.i_start = 1'b1;
            dif.a       = 32'd1;
            dif.b       = 32'd0;
        end
        @(negedge clk);
        dif.i_start = 1'b0;
        check("done_single_pulse", 32'(dif.o_done), 32'd0);
        if (poke_in_done) begin
            @(negedge clk);
            check("start_in_done_busy", 32'(dif.o_busy), 32'd0);
            check("start_in_done_dz", 32'(dif.o_div_zero), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(dif.o_busy), 32'd0);
        check({tag, "_done"}, 32'(dif.o_done), 32'd0);
        check({tag, "_q"},    dif.o_quotient,  32'd0);
        check({tag, "_r"},    dif.o_remainder, 32'd0);
        check({tag, "_dz"},   32'(dif.o_div_zero), 32'd0);
        check({tag, "_ovf"},  32'(dif.overflow),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        dif.i_start  = 1'b0;
        dif.i_signed = 1'b0;
        dif.a        = '0;
        dif.b        = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, 1'b0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(1'b0, 32'd5, 32'd9, 1'b1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b0, 32'd1234, 32'd0, 1'b0);
        do_div(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_div(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31), 1'b0);
        end

        // Abandon an operation with reset; a start mid-run must be ignored.
        @(negedge clk);
        dif.i_start  = 1'b1;
        dif.i_signed = 1'b0;
        dif.a        = 32'd100;
        dif.b        = 32'd7;
        @(negedge clk);
        dif.i_start = 1'b0;
        repeat (9) @(negedge clk);
        dif.i_start = 1'b1;
        dif.a       = 32'd50;
        dif.b       = 32'd0;
        @(negedge clk);
        dif.i_start = 1'b0;
        check("ignored_start_busy", 32'(dif.o_busy), 32'd1);
        check("ignored_start_dz", 32'(dif.o_div_zero), 32'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midop_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.o_done) n_done++;
        end
        check("no_done_after_reset", n_done, 32'd0);
        check("busy_after_reset", 32'(dif.o_busy), 32'd0);

        do_div(1'b0, 32'd9, 32'd3, 1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
